// File: rtl/interrupt_sequencer.sv
// 6502 interrupt/reset entry sequencer: pushes PCH, PCL and P, fetches the vector,
// loads the program counter and sets the I flag.
module interrupt_sequencer #(
    parameter logic [7:0]  STACK_PAGE = 8'h01,
    parameter logic [15:0] VEC_NMI    = 16'hFFFA,
    parameter logic [15:0] VEC_RESET  = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ    = 16'hFFFE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        insn_boundary,
    input  logic        brk_req,
    input  logic        i_flag,
    input  logic [15:0] pc_in,
    input  logic [7:0]  sp_in,
    input  logic [7:0]  psr_in,
    input  logic [7:0]  data_in,
    output logic        busy,
    output logic [15:0] addr,
    output logic        rw,
    output logic [7:0]  data_out,
    output logic        sp_dec,
    output logic        pc_load,
    output logic [15:0] pc_load_value,
    output logic        set_i,
    output logic        done,
    output logic [1:0]  src
);

    typedef enum logic [2:0] {
        StRst, StIdle, StStart, StPch, StPcl, StP, StVl, StVh
    } state_e;

    localparam logic [1:0] SrcIrq   = 2'd0;
    localparam logic [1:0] SrcBrk   = 2'd1;
    localparam logic [1:0] SrcNmi   = 2'd2;
    localparam logic [1:0] SrcReset = 2'd3;

    state_e      state_q, state_d;
    logic [1:0]  src_q, src_d;
    logic        nmi_pend_q, nmi_pend_d;
    logic        nmi_n_q;
    logic [7:0]  vec_lo_q, vec_lo_d;
    logic        nmi_edge;
    logic        is_reset;
    logic [15:0] vec_addr;
    logic [7:0]  push_data;

    assign nmi_edge = nmi_n_q & ~nmi_n;
    assign is_reset = (src_q == SrcReset);
    assign src      = src_q;

    // nmi_n keeps sampling through reset so a pin held low at release is not an edge.
    always_ff @(posedge clk) begin
        nmi_n_q <= nmi_n;
        if (!rst_n) begin
            state_q    <= StRst;
            src_q      <= SrcReset;
            nmi_pend_q <= 1'b0;
            vec_lo_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            nmi_pend_q <= nmi_pend_d;
            vec_lo_q   <= vec_lo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        nmi_pend_d = nmi_pend_q;
        vec_lo_d   = vec_lo_q;
        case (state_q)
            StRst:   state_d = StStart;
            StIdle: begin
                if (insn_boundary) begin
                    if (nmi_pend_q) begin
                        src_d      = SrcNmi;
                        nmi_pend_d = 1'b0;
                        state_d    = StStart;
                    end else if (brk_req) begin
                        src_d   = SrcBrk;
                        state_d = StStart;
                    end else if (!irq_n && !i_flag) begin
                        src_d   = SrcIrq;
                        state_d = StStart;
                    end
                end
            end
            StStart: if (rdy) state_d = StPch;
            StPch:   state_d = StPcl;
            StPcl:   state_d = StP;
            StP:     state_d = StVl;
            StVl: begin
                if (rdy) begin
                    vec_lo_d = data_in;
                    state_d  = StVh;
                end
            end
            StVh:    if (rdy) state_d = StIdle;
            default: state_d = StRst;
        endcase
        // A fresh edge wins over the clear from accepting the previous one.
        if (nmi_edge) nmi_pend_d = 1'b1;
    end

    always_comb begin
        case (src_q)
            SrcNmi:   vec_addr = VEC_NMI;
            SrcReset: vec_addr = VEC_RESET;
            default:  vec_addr = VEC_IRQ;
        endcase
        case (state_q)
            StPch:   push_data = pc_in[15:8];
            StPcl:   push_data = pc_in[7:0];
            default: push_data = {psr_in[7:6], 1'b1, src_q == SrcBrk, psr_in[3:0]};
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        addr          = 16'h0000;
        rw            = 1'b1;
        data_out      = 8'h00;
        sp_dec        = 1'b0;
        pc_load       = 1'b0;
        pc_load_value = 16'h0000;
        set_i         = 1'b0;
        done          = 1'b0;
        case (state_q)
            StStart: begin
                busy = 1'b1;
                addr = pc_in;
            end
            StPch, StPcl, StP: begin
                // RESET walks the stack pointer with reads instead of writes.
                busy     = 1'b1;
                addr     = {STACK_PAGE, sp_in};
                sp_dec   = 1'b1;
                rw       = is_reset;
                data_out = is_reset ? 8'h00 : push_data;
            end
            StVl: begin
                busy = 1'b1;
                addr = vec_addr;
            end
            StVh: begin
                busy          = 1'b1;
                addr          = vec_addr + 16'd1;
                pc_load_value = {data_in, vec_lo_q};
                pc_load       = rdy;
                set_i         = rdy;
                done          = rdy;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Randomized bench: a queue-of-bus-cycles reference model predicts every output each cycle.
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        nmi_n = 1'b1;
    logic        irq_n = 1'b1;
    logic        insn_boundary = 1'b0;
    logic        brk_req = 1'b0;
    logic        i_flag = 1'b1;
    logic [15:0] pc_in = 16'h0000;
    logic [7:0]  sp_in = 8'hFD;
    logic [7:0]  psr_in = 8'h00;
    logic [7:0]  data_in = 8'h00;
    logic        busy;
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  data_out;
    logic        sp_dec;
    logic        pc_load;
    logic [15:0] pc_load_value;
    logic        set_i;
    logic        done;
    logic [1:0]  src;

    interrupt_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rdy           (rdy),
        .nmi_n         (nmi_n),
        .irq_n         (irq_n),
        .insn_boundary (insn_boundary),
        .brk_req       (brk_req),
        .i_flag        (i_flag),
        .pc_in         (pc_in),
        .sp_in         (sp_in),
        .psr_in        (psr_in),
        .data_in       (data_in),
        .busy          (busy),
        .addr          (addr),
        .rw            (rw),
        .data_out      (data_out),
        .sp_dec        (sp_dec),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .set_i         (set_i),
        .done          (done),
        .src           (src)
    );

    always #5 clk = ~clk;

    // One expected bus cycle of a pending sequence.
    typedef struct packed {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  dout;
        logic        spdec;
        logic        stall;  // read cycle that waits for rdy
        logic        cap;    // vector low byte captured here
        logic        last;   // vector high byte, loads PC
    } step_t;

    step_t       q[$];
    bit          in_rst = 1'b1;
    bit          pend_m = 1'b0;
    bit          prev_m = 1'b1;
    logic [1:0]  src_m = 2'd3;
    logic [7:0]  vlo_m = 8'h00;
    logic [7:0]  sp_m = 8'hFD;
    logic [7:0]  psr_m = 8'h00;
    logic [15:0] pc_m = 16'h0000;
    int          n_checks = 0;
    int          n_errs = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic build(input logic [1:0] s);
        logic [15:0] v;
        logic [7:0]  p;
        logic        rd;
        v  = (s == 2'd2) ? 16'hFFFA : (s == 2'd3) ? 16'hFFFC : 16'hFFFE;
        p  = (psr_m & 8'hEF) | 8'h20 | ((s == 2'd1) ? 8'h10 : 8'h00);
        rd = (s == 2'd3);
        q.delete();
        q.push_back('{pc_m, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
        q.push_back('{{8'h01, sp_m}, rd, rd ? 8'h00 : pc_m[15:8], 1'b1, 1'b0, 1'b0, 1'b0});
        q.push_back('{{8'h01, 8'(sp_m - 8'd1)}, rd, rd ? 8'h00 : pc_m[7:0], 1'b1, 1'b0, 1'b0,
                      1'b0});
        q.push_back('{{8'h01, 8'(sp_m - 8'd2)}, rd, rd ? 8'h00 : p, 1'b1, 1'b0, 1'b0, 1'b0});
        q.push_back('{v, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0});
        q.push_back('{16'(v + 16'd1), 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1});
    endtask

    initial begin
        step_t e;
        bit    edge_m;
        bit    active;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(posedge clk);
            #1;
            active = !in_rst && (q.size() != 0);
            if (cyc < 3) rst_n = 1'b0;
            else rst_n = ($urandom_range(0, 149) != 0);
            rdy           = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 24) == 0) nmi_n = ~nmi_n;
            irq_n         = $urandom_range(0, 1) != 0;
            insn_boundary = ($urandom_range(0, 9) < 4);
            brk_req       = ($urandom_range(0, 99) < 15);
            i_flag        = $urandom_range(0, 1) != 0;
            data_in       = 8'($urandom);
            if (!active) begin
                pc_m  = 16'($urandom);
                psr_m = 8'($urandom);
                sp_m  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom);
            end
            pc_in  = pc_m;
            psr_in = psr_m;
            sp_in  = sp_m;

            @(negedge clk);
            if (active) begin
                e = q[0];
                check_val("busy", 32'(busy), 32'd1);
                check_val("addr", 32'(addr), 32'(e.addr));
                check_val("rw", 32'(rw), 32'(e.rw));
                check_val("data_out", 32'(data_out), 32'(e.dout));
                check_val("strobes", {28'd0, sp_dec, pc_load, set_i, done},
                          {28'd0, e.spdec, e.last & rdy, e.last & rdy, e.last & rdy});
                check_val("pc_load_value", 32'(pc_load_value),
                          e.last ? {16'd0, data_in, vlo_m} : 32'd0);
            end else begin
                check_val("busy", 32'(busy), 32'd0);
                check_val("addr", 32'(addr), 32'd0);
                check_val("rw", 32'(rw), 32'd1);
                check_val("data_out", 32'(data_out), 32'd0);
                check_val("strobes", {28'd0, sp_dec, pc_load, set_i, done}, 32'd0);
                check_val("pc_load_value", 32'(pc_load_value), 32'd0);
            end
            check_val("src", 32'(src), 32'(src_m));

            edge_m = prev_m && !nmi_n;
            if (!rst_n) begin
                in_rst = 1'b1;
                q.delete();
                pend_m = 1'b0;
                src_m  = 2'd3;
                vlo_m  = 8'h00;
            end else if (in_rst) begin
                in_rst = 1'b0;
                build(2'd3);
            end else if (q.size() == 0) begin
                if (insn_boundary) begin
                    if (pend_m) begin
                        src_m  = 2'd2;
                        pend_m = 1'b0;
                        build(2'd2);
                    end else if (brk_req) begin
                        src_m = 2'd1;
                        build(2'd1);
                    end else if (!irq_n && !i_flag) begin
                        src_m = 2'd0;
                        build(2'd0);
                    end
                end
            end else begin
                e = q[0];
                if (!e.stall || rdy) begin
                    if (e.cap) vlo_m = data_in;
                    if (e.spdec) sp_m = sp_m - 8'd1;
                    void'(q.pop_front());
                end
            end
            if (rst_n && edge_m) pend_m = 1'b1;
            prev_m = nmi_n;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Sequences the 6502 interrupt/reset entry: push PCH, PCL and P onto the stack page, fetch the vector, load the program counter, set the I flag.
- Sits beside the instruction decoder. It owns the address bus, RW and the stack pointer decrement strobe while busy. The decoder asserts `insn_boundary` on the last cycle of every instruction, and `brk_req` when the instruction just decoded is BRK.

Parameters:
- STACK_PAGE, 8'h01, high address byte for stack pushes
- VEC_NMI, 16'hFFFA, NMI vector low-byte address
- VEC_RESET, 16'hFFFC, RESET vector low-byte address
- VEC_IRQ, 16'hFFFE, IRQ/BRK vector low-byte address

Ports:
- clk  in  1  CPU clock
- rst_n  in  1  reset, synchronous, active-low
- rdy  in  1  1 = bus ready; 0 stalls read cycles
- nmi_n  in  1  NMI pin, active-low, edge-triggered
- irq_n  in  1  IRQ pin, active-low, level-sensitive
- insn_boundary  in  1  decoder: current cycle ends an instruction
- brk_req  in  1  decoder: BRK executing, qualified by insn_boundary
- i_flag  in  1  interrupt-disable flag from status register
- pc_in  in  16  current program counter
- sp_in  in  8  current stack pointer
- psr_in  in  8  current processor status
- data_in  in  8  read data bus
- busy  out  1  sequence in progress; decoder holds off
- addr  out  16  bus address while busy (0 when idle)
- rw  out  1  1 = read, 0 = write
- data_out  out  8  write data
- sp_dec  out  1  decrement stack pointer at end of cycle
- pc_load  out  1  load program counter with pc_load_value
- pc_load_value  out  16  vector target
- set_i  out  1  set I flag at end of cycle
- done  out  1  one-cycle pulse, sequence complete
- src  out  2  event being serviced: 0 = IRQ, 1 = BRK, 2 = NMI, 3 = RESET

Behaviour:
- Interface fixed: one clock `clk`; `rst_n` is synchronous, active-low.
- States: S_RST, S_IDLE, S_START, S_PCH, S_PCL, S_P, S_VL, S_VH.
- Reset:
  - rst_n low at a clk edge → state = S_RST, nmi_pend = 0, vec_lo = 0, src = 3.
  - S_RST drives idle outputs: busy = 0, rw = 1, addr = 0, data_out = 0, all strobes 0, pc_load_value = 0.
  - S_RST → S_START unconditionally; this is the RESET sequence.
  - rst_n low mid-sequence aborts immediately to S_RST; no pending state survives.
- NMI detect:
  - nmi_n is registered each cycle.
  - A registered 1 followed by a sampled 0 sets nmi_pend.
  - nmi_pend clears only when an NMI sequence is accepted.
  - An edge during a sequence remains pending.
- Acceptance, S_IDLE with insn_boundary = 1, priority order:
  - nmi_pend → src = 2
  - else brk_req → src = 1
  - else irq_n = 0 and i_flag = 0 → src = 0
  - else stay in S_IDLE.
  - On acceptance, next state = S_START; src is latched for the whole sequence.
- busy = 1 in S_START through S_VH.
- Per-state outputs (addr, rw, other actions):
  - S_START: addr = pc_in, rw = 1 (dummy read).
  - S_PCH: addr = {STACK_PAGE, sp_in}, data_out = pc_in[15:8], sp_dec = 1.
  - S_PCL: same addressing, data_out = pc_in[7:0], sp_dec = 1.
  - S_P: same addressing, data_out = psr_in with bit5 = 1 and bit4 = (src == 1), sp_dec = 1.
  - S_VL: addr = vector; vec_lo <= data_in at end of cycle.
  - S_VH: addr = vector + 1, rw = 1, pc_load_value = {data_in, vec_lo}, pc_load = 1, set_i = 1, done = 1; next state S_IDLE.
- Push-cycle rw: rw = 0 in S_PCH, S_PCL and S_P, except for RESET (src = 3), where rw = 1 in all three. For RESET, sp_dec is still asserted and data_out = 0.
- Vector select: NMI → VEC_NMI, RESET → VEC_RESET, IRQ/BRK → VEC_IRQ.
- Stack pointer: sp_in reflects the previous sp_dec by the next cycle; sp wraps 8'h00 → 8'hFF naturally. Address is always {STACK_PAGE, sp_in}.
- RDY:
  - rdy = 0 holds state and all outputs in read states (S_START, S_VL, S_VH).
  - While held, vec_lo is not captured and pc_load/set_i/done are suppressed.
  - Write states (S_PCH, S_PCL, S_P) ignore rdy.
  - For RESET, S_PCH/S_PCL/S_P are reads but still ignore rdy.
- Sequence length with rdy = 1: 6 cycles S_START..S_VH; done in the 6th cycle.
- Events during busy are ignored except NMI latching. irq_n is re-evaluated at the next boundary.

Test Plan:
- Reset release: rst_n 0→1, sp_in = 8'hFD, mem[FFFC] = 34, mem[FFFD] = 12 → cycle 1 S_RST idle, then 6 cycles. No rw = 0 cycle; sp_dec three times; pc_load_value = 16'h1234; done = 1; src = 3.
- IRQ: pc = 16'h8003, sp = 8'hFF, psr = 8'h00, i_flag = 0, irq_n = 0, boundary → writes 01FF = 80, 01FE = 03, 01FD = 20; vector FFFE/FFFF; set_i = 1; src = 0.
- BRK vs IRQ masked: brk_req = 1, i_flag = 1, irq_n = 0 → BRK serviced, pushed P bit4 = 1, vector FFFE. With i_flag = 1 and no brk_req, irq_n = 0 gives no sequence.
- NMI priority and latching: nmi_n falls during an IRQ sequence → IRQ completes. At the next boundary NMI is serviced (vector FFFA, P bit4 = 0), nmi_pend cleared. A held-low nmi_n does not retrigger.
- RDY stall: rdy = 0 for 3 cycles in S_VL → addr stays at the vector, state held, done delayed exactly 3 cycles. rdy = 0 in S_PCH → write proceeds without stall.
- Reset mid-sequence: rst_n = 0 during S_PCL → next cycle S_RST, busy = 0, nmi_pend = 0. After release, a full RESET sequence runs.
